// File: rtl/a2d_scan_ctrl.sv
// Round-robin scan sequencer for an ADC128S-style 12-bit A2D behind a SPI master,
// with priority host conversions. Optional macro A2D_AVG_EN: table holds a 3:1 running average.
module a2d_scan_ctrl #(
  parameter int NUM_CH   = 8,
  parameter int SCAN_GAP = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic        host_req,
  input  logic [2:0]  host_ch,
  output logic        host_gnt,
  output logic        host_rdy,
  output logic [11:0] host_data,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data
);
  localparam int GW = $clog2(SCAN_GAP + 1);
  localparam logic [3:0]    NUM_CH_L = 4'(NUM_CH);
  localparam logic [2:0]    LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(SCAN_GAP);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CAPT = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [2:0]    scan_ptr_q, scan_ptr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pend_vld_q, pend_vld_d;
  logic [2:0]    pend_ch_q, pend_ch_d;
  logic          pend_host_q, pend_host_d;
  logic          slot_vld_q, slot_vld_d;
  logic          slot_host_q, slot_host_d;
  logic          spi_wrt_q, spi_wrt_d;
  logic [15:0]   spi_cmd_q, spi_cmd_d;
  logic          host_gnt_q, host_gnt_d;
  logic          host_rdy_q, host_rdy_d;
  logic [11:0]   host_data_q, host_data_d;
  logic [11:0]   tbl_q [0:7];
  logic [11:0]   tbl_d [0:7];
  logic [3:0]    unused_rd_s;

`ifdef A2D_AVG_EN
  logic          seen_q [0:7];
  logic          seen_d [0:7];

  function automatic logic [11:0] avg3(input logic [11:0] old_v, input logic [11:0] new_v);
    logic [13:0] sum;
    sum = ({2'b00, old_v} * 14'd3) + {2'b00, new_v};
    return sum[13:2];
  endfunction
`endif

  assign unused_rd_s = spi_rd[15:12];
  assign spi_wrt     = spi_wrt_q;
  assign spi_cmd     = spi_cmd_q;
  assign host_gnt    = host_gnt_q;
  assign host_rdy    = host_rdy_q;
  assign host_data   = host_data_q;
  assign rd_data     = ({1'b0, rd_ch} < NUM_CH_L) ? tbl_q[rd_ch] : 12'h000;

  // Slot selection, pending-result tracking and table capture.
  always_comb begin
    state_d     = state_q;
    scan_ptr_d  = scan_ptr_q;
    gap_d       = (gap_q != GW'(0)) ? (gap_q - GW'(1)) : gap_q;
    pend_vld_d  = pend_vld_q;
    pend_ch_d   = pend_ch_q;
    pend_host_d = pend_host_q;
    slot_vld_d  = slot_vld_q;
    slot_host_d = slot_host_q;
    spi_wrt_d   = 1'b0;
    spi_cmd_d   = spi_cmd_q;
    host_gnt_d  = 1'b0;
    host_rdy_d  = 1'b0;
    host_data_d = host_data_q;
    for (int i = 0; i < 8; i++) begin
      tbl_d[i] = tbl_q[i];
`ifdef A2D_AVG_EN
      seen_d[i] = seen_q[i];
`endif
    end

    case (state_q)
      IDLE: begin
        if (host_req && !(pend_vld_q && pend_host_q)) begin
          state_d     = WAIT;
          spi_wrt_d   = 1'b1;
          host_gnt_d  = 1'b1;
          spi_cmd_d   = {2'b00, host_ch, 11'h000};
          slot_vld_d  = 1'b1;
          slot_host_d = 1'b1;
        end else if (scan_en && (gap_q == GW'(0))) begin
          state_d     = WAIT;
          spi_wrt_d   = 1'b1;
          spi_cmd_d   = {2'b00, scan_ptr_q, 11'h000};
          slot_vld_d  = 1'b1;
          slot_host_d = 1'b0;
          if (scan_ptr_q == LAST_CH) begin
            scan_ptr_d = 3'd0;
            gap_d      = GAP_LOAD;
          end else begin
            scan_ptr_d = scan_ptr_q + 3'd1;
          end
        end else if (pend_vld_q && (!scan_en || pend_host_q)) begin
          // Flush: a dummy ch0 access whose only purpose is to collect the owed result.
          state_d     = WAIT;
          spi_wrt_d   = 1'b1;
          spi_cmd_d   = 16'h0000;
          slot_vld_d  = 1'b0;
          slot_host_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (spi_done) begin
          state_d = CAPT;
          if (pend_vld_q && ({1'b0, pend_ch_q} < NUM_CH_L)) begin
`ifdef A2D_AVG_EN
            tbl_d[pend_ch_q]  = seen_q[pend_ch_q] ? avg3(tbl_q[pend_ch_q], spi_rd[11:0])
                                                  : spi_rd[11:0];
            seen_d[pend_ch_q] = 1'b1;
`else
            tbl_d[pend_ch_q] = spi_rd[11:0];
`endif
          end else begin
            tbl_d[pend_ch_q] = tbl_q[pend_ch_q];
          end
          if (pend_vld_q && pend_host_q) begin
            host_data_d = spi_rd[11:0];
            host_rdy_d  = 1'b1;
          end else begin
            host_rdy_d = 1'b0;
          end
          // Data in this transaction belonged to the previous slot; now track the one just issued.
          pend_vld_d  = slot_vld_q;
          pend_ch_d   = spi_cmd_q[13:11];
          pend_host_d = slot_host_q;
        end else begin
          state_d = WAIT;
        end
      end
      CAPT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scan_ptr_q  <= 3'd0;
      gap_q       <= GW'(0);
      pend_vld_q  <= 1'b0;
      pend_ch_q   <= 3'd0;
      pend_host_q <= 1'b0;
      slot_vld_q  <= 1'b0;
      slot_host_q <= 1'b0;
      spi_wrt_q   <= 1'b0;
      spi_cmd_q   <= 16'h0000;
      host_gnt_q  <= 1'b0;
      host_rdy_q  <= 1'b0;
      host_data_q <= 12'h000;
      for (int i = 0; i < 8; i++) begin
        tbl_q[i] <= 12'h000;
`ifdef A2D_AVG_EN
        seen_q[i] <= 1'b0;
`endif
      end
    end else begin
      state_q     <= state_d;
      scan_ptr_q  <= scan_ptr_d;
      gap_q       <= gap_d;
      pend_vld_q  <= pend_vld_d;
      pend_ch_q   <= pend_ch_d;
      pend_host_q <= pend_host_d;
      slot_vld_q  <= slot_vld_d;
      slot_host_q <= slot_host_d;
      spi_wrt_q   <= spi_wrt_d;
      spi_cmd_q   <= spi_cmd_d;
      host_gnt_q  <= host_gnt_d;
      host_rdy_q  <= host_rdy_d;
      host_data_q <= host_data_d;
      for (int i = 0; i < 8; i++) begin
        tbl_q[i] <= tbl_d[i];
`ifdef A2D_AVG_EN
        seen_q[i] <= seen_d[i];
`endif
      end
    end
  end
endmodule
